// File: rtl/tile_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tile_fetch_buffer
//
// Ping-pong input buffer for the conv/dw-conv array. Whole tiles of
// NROW rows x BUFW words are fetched into one bank over an AXI-style read
// channel, one row per burst. The PE array reads the other bank at the same
// time. Ownership of each bank is tracked by bank_vld (set when a tile fill
// completes) and bank_rel/rel_sel (consumer hands a bank back).
//
// Optional feature: define ZERO_PAD_EN to add cfg_pad_top/cfg_pad_bot. Padding
// rows at the top of the first tile and the bottom of the last tile are then
// zero-filled locally instead of being fetched.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: latch cfg_* and begin a map (ignored if busy)
//   cfg_base              byte address of row 0 of tile 0
//   cfg_row_pitch         byte distance between rows
//   cfg_tile_step         byte advance between tiles
//   cfg_ntile             tiles per map, 0 = no fetch
//   cfg_pad_top/bot       (ZERO_PAD_EN only) padding rows at top/bottom
//   araddr/arvalid/arready/arlen   read address channel
//   rdata/rvalid/rlast/rready      read data channel
//   bank_vld              per-bank "holds a complete tile"
//   bank_rel/rel_sel      consumer releases bank rel_sel
//   rd_bank/rd_row/rd_col read select, odata one cycle later
//   blkend                pulse: a tile fill completed
//   mapend                pulse: the map completed
//   busy                  map in progress
//   err                   sticky burst-length error (cleared by start)
// ---------------------------------------------------------------------------
module tile_fetch_buffer #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int BUFW = 32,
  parameter int NROW = 5,
  parameter int TW   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AW-1:0]             cfg_base,
  input  logic [AW-1:0]             cfg_row_pitch,
  input  logic [AW-1:0]             cfg_tile_step,
  input  logic [TW-1:0]             cfg_ntile,
`ifdef ZERO_PAD_EN
  input  logic [2:0]                cfg_pad_top,
  input  logic [2:0]                cfg_pad_bot,
`endif
  output logic [AW-1:0]             araddr,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [7:0]                arlen,
  input  logic [DW-1:0]             rdata,
  input  logic                      rvalid,
  input  logic                      rlast,
  output logic                      rready,
  output logic [1:0]                bank_vld,
  input  logic                      bank_rel,
  input  logic                      rel_sel,
  input  logic                      rd_bank,
  input  logic [$clog2(NROW)-1:0]   rd_row,
  input  logic [$clog2(BUFW)-1:0]   rd_col,
  output logic [DW-1:0]             odata,
  output logic                      blkend,
  output logic                      mapend,
  output logic                      busy,
  output logic                      err
);

  localparam int RW = $clog2(NROW);
  localparam int CW = $clog2(BUFW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NROW - 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BUFW - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAITBANK = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_FILLED   = 3'd4;
`ifdef ZERO_PAD_EN
  localparam logic [2:0] S_ZFILL    = 3'd5;
`endif

  logic [2:0]    state_reg;
  logic          wb_reg;          // bank currently being filled
  logic [RW-1:0] row_reg;
  logic [CW-1:0] beat_reg;
  logic          drain_reg;       // row already complete, discarding beats until rlast
  logic [TW-1:0] tile_reg;
  logic [AW-1:0] rowaddr_reg;
  logic [AW-1:0] tile_base_reg;
  logic [AW-1:0] row_pitch_reg;
  logic [AW-1:0] tile_step_reg;
  logic [TW-1:0] ntile_reg;
  logic [1:0]    bank_vld_reg;
  logic [1:0]    bank_vld_next;
  logic          blkend_reg;
  logic          mapend_reg;
  logic          busy_reg;
  logic          err_reg;
  logic [DW-1:0] odata_reg;

  logic [DW-1:0] mem [2][NROW][BUFW];
  logic          mem_we;
  logic [DW-1:0] mem_wdata;

  logic          row_done;
  logic          row_pad;         // current row is a padding row
  logic [2:0]    entry_state;     // state that starts the current row
  logic [2:0]    next_entry_state;// state that starts the following row
  logic [TW-1:0] tile_inc;
  logic [AW-1:0] tile_base_inc;

`ifdef ZERO_PAD_EN
  logic [2:0]    pad_top_reg;
  logic [2:0]    pad_bot_reg;
  logic [TW-1:0] last_tile;
  logic          nxt_pad;

  assign last_tile = ntile_reg - TW'(1);
  assign row_pad =
      ((tile_reg == '0) && (int'(row_reg) < int'(pad_top_reg))) ||
      ((tile_reg == last_tile) && (int'(row_reg) + int'(pad_bot_reg) >= NROW));
  assign nxt_pad =
      ((tile_reg == '0) && (int'(row_reg) + 1 < int'(pad_top_reg))) ||
      ((tile_reg == last_tile) && (int'(row_reg) + 1 + int'(pad_bot_reg) >= NROW));
  assign entry_state      = row_pad ? S_ZFILL : S_ADDR;
  assign next_entry_state = nxt_pad ? S_ZFILL : S_ADDR;
`else
  assign row_pad          = 1'b0;
  assign entry_state      = S_ADDR;
  assign next_entry_state = S_ADDR;
`endif

  assign tile_inc      = tile_reg + TW'(1);
  assign tile_base_inc = tile_base_reg + tile_step_reg;

  // A fetched row finishes on the rlast that closes its burst: either the
  // well-formed one at the final beat, or the late one after draining.
  always_comb begin
    row_done = 1'b0;
    if (state_reg == S_DATA && rvalid && rlast && (drain_reg || beat_reg == BEAT_LAST))
      row_done = 1'b1;
`ifdef ZERO_PAD_EN
    if (state_reg == S_ZFILL && beat_reg == BEAT_LAST)
      row_done = 1'b1;
`endif
  end

  // Per-bank valid: release clears, fill completion sets; set wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_vld_next[gi] =
        ((state_reg == S_FILLED) && (wb_reg == 1'(gi))) ||
        (bank_vld_reg[gi] && !(bank_rel && (rel_sel == 1'(gi))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      wb_reg        <= 1'b0;
      row_reg       <= '0;
      beat_reg      <= '0;
      drain_reg     <= 1'b0;
      tile_reg      <= '0;
      rowaddr_reg   <= '0;
      tile_base_reg <= '0;
      row_pitch_reg <= '0;
      tile_step_reg <= '0;
      ntile_reg     <= '0;
`ifdef ZERO_PAD_EN
      pad_top_reg   <= '0;
      pad_bot_reg   <= '0;
`endif
      bank_vld_reg  <= '0;
      blkend_reg    <= 1'b0;
      mapend_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      blkend_reg   <= 1'b0;
      mapend_reg   <= 1'b0;
      bank_vld_reg <= bank_vld_next;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            row_pitch_reg <= cfg_row_pitch;
            tile_step_reg <= cfg_tile_step;
            ntile_reg     <= cfg_ntile;
`ifdef ZERO_PAD_EN
            pad_top_reg   <= cfg_pad_top;
            pad_bot_reg   <= cfg_pad_bot;
`endif
            tile_reg      <= '0;
            row_reg       <= '0;
            rowaddr_reg   <= cfg_base;
            tile_base_reg <= cfg_base;
            err_reg       <= 1'b0;
            if (cfg_ntile == '0) begin
              mapend_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= S_WAITBANK;
            end
          end
        end

        S_WAITBANK: begin
          if (!bank_vld_reg[wb_reg]) begin
            beat_reg  <= '0;
            state_reg <= entry_state;
          end
        end

        S_ADDR: begin
          if (arready) begin
            beat_reg  <= '0;
            drain_reg <= 1'b0;
            state_reg <= S_DATA;
          end
        end

        S_DATA: begin
          if (rvalid && !drain_reg) begin
            if (beat_reg == BEAT_LAST) begin
              // Missing rlast: keep the row, swallow the rest of the burst.
              if (!rlast) begin
                err_reg   <= 1'b1;
                drain_reg <= 1'b1;
              end
            end else begin
              beat_reg <= beat_reg + CW'(1);
              if (rlast)
                err_reg <= 1'b1;
            end
          end
        end

`ifdef ZERO_PAD_EN
        S_ZFILL: begin
          if (beat_reg != BEAT_LAST)
            beat_reg <= beat_reg + CW'(1);
        end
`endif

        S_FILLED: begin
          blkend_reg    <= 1'b1;
          wb_reg        <= ~wb_reg;
          row_reg       <= '0;
          tile_base_reg <= tile_base_inc;
          rowaddr_reg   <= tile_base_inc;
          tile_reg      <= tile_inc;
          if (tile_inc == ntile_reg) begin
            mapend_reg <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= S_IDLE;
          end else begin
            state_reg  <= S_WAITBANK;
          end
        end

        default: state_reg <= S_IDLE;
      endcase

      if (row_done) begin
        beat_reg  <= '0;
        drain_reg <= 1'b0;
        if (row_reg == ROW_LAST) begin
          state_reg <= S_FILLED;
        end else begin
          row_reg <= row_reg + RW'(1);
          // Padding rows consume no address space.
          if (!row_pad)
            rowaddr_reg <= rowaddr_reg + row_pitch_reg;
          state_reg <= next_entry_state;
        end
      end
    end
  end

  // Buffer write port: fetched beats, or zeros while padding.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = rdata;
    if (state_reg == S_DATA && rvalid && !drain_reg)
      mem_we = 1'b1;
`ifdef ZERO_PAD_EN
    if (state_reg == S_ZFILL) begin
      mem_we    = 1'b1;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wb_reg][row_reg][beat_reg] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      odata_reg <= '0;
    else
      odata_reg <= mem[rd_bank][rd_row][rd_col];
  end

  assign araddr   = rowaddr_reg;
  assign arvalid  = (state_reg == S_ADDR);
  assign arlen    = 8'(BUFW - 1);
  assign rready   = (state_reg == S_DATA);
  assign bank_vld = bank_vld_reg;
  assign odata    = odata_reg;
  assign blkend   = blkend_reg;
  assign mapend   = mapend_reg;
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_tile_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_tile_fetch_buffer
//
// Directed testbench for tile_fetch_buffer. A small AXI read slave returns
// rdata = beat + 32*row and can inject an early rlast on one chosen burst.
// Build with ZERO_PAD_EN defined to also exercise the padding rows.
// ---------------------------------------------------------------------------
module tb_tile_fetch_buffer;

  localparam int DW = 32, AW = 32, BUFW = 32, NROW = 5, TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_base, cfg_row_pitch, cfg_tile_step;
  logic [TW-1:0] cfg_ntile;
`ifdef ZERO_PAD_EN
  logic [2:0]    cfg_pad_top, cfg_pad_bot;
`endif
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [7:0]    arlen;
  logic [DW-1:0] rdata = '0;
  logic          rvalid = 1'b0;
  logic          rlast = 1'b0;
  logic          rready;
  logic [1:0]    bank_vld;
  logic          bank_rel, rel_sel, rd_bank;
  logic [2:0]    rd_row;
  logic [4:0]    rd_col;
  logic [DW-1:0] odata;
  logic          blkend, mapend, busy, err;

  always #5 clk = ~clk;

  tile_fetch_buffer #(.DW(DW), .AW(AW), .BUFW(BUFW), .NROW(NROW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base(cfg_base), .cfg_row_pitch(cfg_row_pitch),
    .cfg_tile_step(cfg_tile_step), .cfg_ntile(cfg_ntile),
`ifdef ZERO_PAD_EN
    .cfg_pad_top(cfg_pad_top), .cfg_pad_bot(cfg_pad_bot),
`endif
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .bank_vld(bank_vld), .bank_rel(bank_rel), .rel_sel(rel_sel),
    .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col), .odata(odata),
    .blkend(blkend), .mapend(mapend), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave + event monitor. Everything is driven/sampled on the falling edge;
  // seen_* hold what the DUT presented at the rising edge just passed.
  logic [31:0] addr_q[$];
  logic [1:0]  blk_vld_q[$];
  int          blk_burst_q[$];
  int          blk_cnt = 0, map_cnt = 0, arv_cnt = 0;
  int          early_burst = -1;
  bit          slv_busy = 1'b0;
  int          slv_beat = 0, slv_row = 0;
  logic        seen_arvalid = 1'b0, seen_rready = 1'b0;
  logic [31:0] seen_araddr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      slv_busy = 1'b0; slv_beat = 0;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0;
      seen_arvalid = 1'b0; seen_rready = 1'b0;
    end else begin
      if (seen_arvalid && arready) begin
        addr_q.push_back(seen_araddr);
        slv_busy = 1'b1;
        slv_beat = 0;
        slv_row  = (addr_q.size() - 1) % NROW;
      end else if (rvalid && seen_rready) begin
        if (slv_beat == BUFW - 1) slv_busy = 1'b0;
        else slv_beat++;
      end
      rvalid = slv_busy;
      rdata  = 32'(slv_beat + 32 * slv_row);
      rlast  = slv_busy && ((slv_beat == BUFW - 1) ||
               ((addr_q.size() - 1 == early_burst) && (slv_beat == 10)));
      seen_arvalid = arvalid;
      seen_araddr  = araddr;
      seen_rready  = rready;
      if (blkend) begin
        blk_cnt++;
        blk_vld_q.push_back(bank_vld);
        blk_burst_q.push_back(addr_q.size());
      end
      if (mapend)  map_cnt++;
      if (arvalid) arv_cnt++;
    end
    arready = 1'b1;
  end

  task automatic start_map(input logic [31:0] base, input logic [31:0] pitch,
                           input logic [31:0] step, input int ntile);
    @(negedge clk);
    cfg_base = base; cfg_row_pitch = pitch; cfg_tile_step = step;
    cfg_ntile = TW'(ntile);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_map(input int prev);
    int n = 0;
    while (map_cnt == prev && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("map_done", 64'(map_cnt != prev), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic release_bank(input logic b);
    @(negedge clk);
    bank_rel = 1'b1; rel_sel = b;
    @(negedge clk);
    bank_rel = 1'b0;
  endtask

  task automatic rd_word(input logic b, input int r, input int c, output logic [31:0] v);
    @(negedge clk);
    rd_bank = b; rd_row = 3'(r); rd_col = 5'(c);
    @(negedge clk);
    v = odata;
  endtask

  initial begin
    logic [31:0] v;
    int m0, a0, b0, q0, n;
    bit busy_seen;

    rst_n = 1'b0; start = 1'b0;
    cfg_base = '0; cfg_row_pitch = '0; cfg_tile_step = '0; cfg_ntile = '0;
`ifdef ZERO_PAD_EN
    cfg_pad_top = '0; cfg_pad_bot = '0;
`endif
    bank_rel = 1'b0; rel_sel = 1'b0; rd_bank = 1'b0; rd_row = '0; rd_col = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_arvalid",  64'(arvalid),  64'd0);
    check("rst_rready",   64'(rready),   64'd0);
    check("rst_bank_vld", 64'(bank_vld), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_err",      64'(err),      64'd0);
    check("rst_araddr",   64'(araddr),   64'd0);
    check("rst_odata",    64'(odata),    64'd0);
    check("rst_pulses",   64'({blkend, mapend}), 64'd0);
    check("arlen",        64'(arlen),    64'd31);

    // ntile = 0: single mapend, no fetch, never busy
    m0 = map_cnt; a0 = arv_cnt; busy_seen = 1'b0;
    start_map(32'h1000, 32'h400, 32'h800, 0);
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
    end
    check("n0_mapend",  64'(map_cnt - m0), 64'd1);
    check("n0_arvalid", 64'(arv_cnt - a0), 64'd0);
    check("n0_busy",    64'(busy_seen),    64'd0);

    // Basic map: 2 tiles, 10 bursts
    m0 = map_cnt; b0 = blk_cnt; q0 = addr_q.size();
    start_map(32'h1000, 32'h400, 32'h800, 2);
    check("basic_busy", 64'(busy), 64'd1);
    wait_map(m0);
    check("basic_nburst", 64'(addr_q.size() - q0), 64'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("basic_araddr%0d", i), 64'(addr_q[q0 + i]),
            64'(32'h1000 + (i / 5) * 32'h800 + (i % 5) * 32'h400));
    check("basic_blkcnt",  64'(blk_cnt - b0),        64'd2);
    check("basic_blk0vld", 64'(blk_vld_q[b0]),       64'b01);
    check("basic_blk1vld", 64'(blk_vld_q[b0 + 1]),   64'b11);
    check("basic_blk0at",  64'(blk_burst_q[b0]),     64'(q0 + 5));
    check("basic_blk1at",  64'(blk_burst_q[b0 + 1]), 64'(q0 + 10));
    check("basic_mapend",  64'(map_cnt - m0),        64'd1);
    check("basic_idle",    64'(busy),                64'd0);
    check("basic_vld",     64'(bank_vld),            64'b11);
    check("basic_err",     64'(err),                 64'd0);

    // Read port
    rd_word(1'b0, 3, 7, v);  check("rd_b0r3c7",  64'(v), 64'd103);
    rd_word(1'b1, 4, 31, v); check("rd_b1r4c31", 64'(v), 64'd159);
    rd_word(1'b1, 2, 1, v);  check("rd_b1r2c1",  64'(v), 64'd65);
    rd_word(1'b0, 0, 5, v);  check("rd_b0r0c5",  64'(v), 64'd5);

    // Backpressure: both banks full, FSM must wait
    m0 = map_cnt; a0 = arv_cnt; q0 = addr_q.size(); b0 = blk_cnt;
    start_map(32'h8000, 32'h40, 32'h1000, 1);
    repeat (20) @(negedge clk);
    check("bp_noarvalid", 64'(arv_cnt - a0), 64'd0);
    check("bp_busy",      64'(busy),         64'd1);
    release_bank(1'b0);
    check("bp_rel_vld",   64'(bank_vld),     64'b10);
    n = 1;
    while (!arvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_ar_latency", 64'(n <= 2), 64'd1);
    check("bp_araddr",     64'(araddr), 64'h8000);
    // Releasing a bank that is not valid changes nothing.
    release_bank(1'b0);
    check("bp_rel_ignored", 64'(bank_vld), 64'b10);
    wait_map(m0);
    check("bp_nburst",  64'(addr_q.size() - q0), 64'd5);
    check("bp_last_ad", 64'(addr_q[q0 + 4]),     64'h8100);
    check("bp_blkvld",  64'(blk_vld_q[b0]),      64'b11);

    // Early rlast on beat 10 of the second row
    m0 = map_cnt; q0 = addr_q.size();
    release_bank(1'b1);
    early_burst = q0 + 1;
    start_map(32'h20000, 32'h100, 32'h0, 1);
    wait_map(m0);
    early_burst = -1;
    check("early_err",    64'(err),                 64'd1);
    check("early_nburst", 64'(addr_q.size() - q0),  64'd5);
    check("early_next",   64'(addr_q[q0 + 2]),      64'h20200);
    rd_word(1'b1, 1, 20, v); check("early_b1r1c20", 64'(v), 64'd52);
    rd_word(1'b1, 1, 31, v); check("early_b1r1c31", 64'(v), 64'd63);
    start_map(32'h0, 32'h0, 32'h0, 0);
    check("err_clr_by_start", 64'(err), 64'd0);

`ifdef ZERO_PAD_EN
    // Padding: first row of tile 0 and last row of tile 1 are zero-filled
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("pad_rst_vld", 64'(bank_vld), 64'd0);
    cfg_pad_top = 3'd1; cfg_pad_bot = 3'd1;
    m0 = map_cnt; q0 = addr_q.size();
    start_map(32'h1000, 32'h400, 32'h800, 2);
    wait_map(m0);
    check("pad_nburst", 64'(addr_q.size() - q0), 64'd8);
    check("pad_first",  64'(addr_q[q0]),         64'h1000);
    check("pad_t1r0",   64'(addr_q[q0 + 4]),     64'h1800);
    check("pad_t1r3",   64'(addr_q[q0 + 7]),     64'h2400);
    rd_word(1'b0, 0, 5, v); check("pad_b0r0c5", 64'(v), 64'd0);
    rd_word(1'b1, 4, 9, v); check("pad_b1r4c9", 64'(v), 64'd0);
    rd_word(1'b0, 1, 5, v); check("pad_b0r1_nonzero", 64'(v != 0), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_fetch_buffer.md
Name: tile_fetch_buffer

Overview:
- Next-generation input buffer for the conv/dw-conv array.
- Fetches image tiles of NROW rows × BUFW words from memory over an AXI-style read channel into two ping-pong banks. The next tile is fetched while the PE array reads the current one.
- Base, row pitch, tile advance and tile count are set at runtime. Bank ownership is tracked with explicit per-bank valid/release handshakes.

Parameters:
- DW, 32, data word width.
- AW, 32, address width.
- BUFW, 32, words per row; equals burst length.
- NROW, 5, rows per tile (KSIZE+(POY-1)*STRIDE).
- TW, 16, width of the tile counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  pulse; latch cfg_* and begin a map.
- cfg_base  in  AW  byte address of row 0 of tile 0.
- cfg_row_pitch  in  AW  byte distance between rows.
- cfg_tile_step  in  AW  byte advance between tiles.
- cfg_ntile  in  TW  tiles per map; 0 means no fetch.
- araddr  out  AW  burst start address.
- arvalid  out  1  address valid.
- arready  in  1  address accepted.
- arlen  out  8  constant BUFW-1.
- rdata  in  DW  read data.
- rvalid  in  1  beat valid.
- rlast  in  1  last beat.
- rready  out  1  data ready.
- bank_vld  out  2  bank b holds a complete tile.
- bank_rel  in  1  consumer releases a bank.
- rel_sel  in  1  bank being released.
- rd_bank  in  1  read select: bank.
- rd_row  in  $clog2(NROW)  read select: row.
- rd_col  in  $clog2(BUFW)  read select: column.
- odata  out  DW  read word, 1-cycle latency.
- blkend  out  1  1-cycle pulse when a tile fill completes.
- mapend  out  1  1-cycle pulse after the last tile fills.
- busy  out  1  map in progress.
- err  out  1  sticky burst-length error.

Behaviour:
- Reset values: arvalid, rready, bank_vld, blkend, mapend, busy and err are 0; araddr is 0; odata is 0; FSM is IDLE; write bank pointer wb=0. A reset mid-burst drops all state; beats still in flight are never accepted because rready=0.
- States:
  - IDLE: on start, latch cfg_*, set tile=0, row=0, rowaddr=cfg_base. If cfg_ntile==0, pulse mapend the next cycle and stay in IDLE. Otherwise set busy=1 and go to WAITBANK.
  - WAITBANK: go to ADDR when bank_vld[wb]==0; stall otherwise.
  - ADDR: drive araddr=rowaddr and arvalid=1. Hold both stable until arready. On handshake, go to DATA.
  - DATA: rready=1. Each rvalid beat writes rdata to bank wb, row `row`, column beat count, then increments the count. Only one burst is outstanding at a time.
    - If rlast arrives at beat BUFW-1, the row is done.
    - If rlast arrives early, or is absent at beat BUFW-1, set err. Still terminate the row at beat BUFW-1 and ignore beats after that until rlast.
    - Row done, row<NROW-1: row++, rowaddr+=cfg_row_pitch, go to ADDR.
    - Row done, row==NROW-1: go to FILLED.
  - FILLED (1 cycle):
    - Set bank_vld[wb], pulse blkend, toggle wb, row=0.
    - tile_base+=cfg_tile_step, and rowaddr=new tile_base.
    - tile++. If tile==cfg_ntile, pulse mapend, clear busy and go to IDLE. Otherwise go to WAITBANK.
- Release: bank_rel clears bank_vld[rel_sel] on the next edge.
  - Release of a bank that is not valid is ignored.
  - If a set and a clear of the same bank hit in one cycle, the set wins. The consumer cannot legally release a bank before it is set.
- start while busy: ignored.
- Read port: odata <= mem[rd_bank][rd_row][rd_col] on every edge. Reads are unrestricted. Reading the bank being filled returns mixed old/new data; the consumer gates on bank_vld.
- Address arithmetic: modulo 2^AW, no overflow detection.
- err: cleared only by reset or by start.

Optional Feature:
- Macro ZERO_PAD_EN.
- When defined:
  - Adds input cfg_pad_top (3 bits) and input cfg_pad_bot (3 bits).
  - For tile 0, rows < cfg_pad_top are padding rows.
  - For the last tile, rows >= NROW-cfg_pad_bot are padding rows.
  - A padding row is not fetched over AXI. Instead the FSM stays in a ZFILL state for BUFW cycles writing zeros to that row, then advances exactly as a fetched row would. rowaddr advances only on fetched rows.
- When undefined: no pad ports, no ZFILL state; every row is fetched.

Test Plan:
- Basic map: base=0x1000, pitch=0x400, step=0x800, ntile=2, arready and rvalid always high → 10 bursts with araddr 0x1000, 0x1400, …, 0x2000, then 0x1800, …; blkend after each 5th burst; bank_vld=01 then 11; mapend once.
- Backpressure: release withheld → after both banks fill, the FSM sits in WAITBANK with arvalid=0. bank_rel with rel_sel=0 → the next araddr is issued within 2 cycles and fills bank 0.
- Read port: after fill with rdata = beat index + 32*row → reading bank 0, row 3, col 7 returns 103 one cycle later.
- Early rlast on beat 10 → err=1; the row still completes at beat 31; the next address issues normally.
- cfg_ntile=0 → no arvalid; mapend pulses once; busy stays 0.
- ZERO_PAD_EN with pad_top=1, pad_bot=1, ntile=2 → tile 0 row 0 and tile 1 row 4 read as all zeros; 8 bursts total; the first araddr equals cfg_base.
